// File: rtl/vinsn_issue_queue.sv
// Vector instruction issue queue: FWFT FIFO with an outstanding-instruction limit.
// Head visible the cycle after enqueue; ready_o drops when full or flushing.

package vinsn_issue_queue_pkg;
  typedef logic [7:0]  insn_id_t;
  typedef logic [63:0] xlen_t;
  typedef struct packed {
    logic [7:0]  vtype;
    logic [15:0] vl;
  } vec_context_t;
endpackage

module vinsn_issue_queue
  import vinsn_issue_queue_pkg::*;
#(
  parameter int unsigned Depth       = 4,
  parameter int unsigned MaxInflight = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            insn_i,
  input  insn_id_t               insn_id_i,
  input  xlen_t                  scalar_reg_i,
  input  vec_context_t           vec_context_i,
  input  logic                   flush_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            insn_o,
  output insn_id_t               insn_id_o,
  output xlen_t                  scalar_reg_o,
  output vec_context_t           vec_context_o,
  input  logic                   done_i,
  output logic [$clog2(Depth):0] count_o,
  output logic [3:0]             inflight_o,
  output logic                   err_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0]  insn;
    insn_id_t     id;
    xlen_t        scalar;
    vec_context_t ctx;
  } entry_t;

  entry_t         mem_q [Depth];
  entry_t         head;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [3:0]     inflight_q, inflight_d;
  logic           err_q, err_d;
  logic           push, pop;

  assign ready_o       = (count_q != CW'(Depth)) && !flush_i;
  assign issue_valid_o = (count_q != '0) && (inflight_q != 4'(MaxInflight)) && !flush_i;
  assign push          = valid_i && ready_o;
  assign pop           = issue_valid_o && issue_ready_i;

  assign head          = mem_q[rptr_q];
  assign insn_o        = head.insn;
  assign insn_id_o     = head.id;
  assign scalar_reg_o  = head.scalar;
  assign vec_context_o = head.ctx;

  assign count_o       = count_q;
  assign inflight_o    = inflight_q;
  assign err_o         = err_q;

  always_comb begin
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    if (flush_i) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end

    // Retire tracking runs regardless of flush: issued instructions are already in rvv_core.
    if (pop && !done_i) begin
      inflight_d = inflight_q + 4'd1;
    end else if (done_i && !pop) begin
      if (inflight_q == 4'd0) err_d = 1'b1;
      else                    inflight_d = inflight_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {insn_i, insn_id_i, scalar_reg_i, vec_context_i};
  end

endmodule

// File: doc/vinsn_issue_queue.md
VINSN_ISSUE_QUEUE -- requirements
Module: vinsn_issue_queue

Interface
REQ-001 SHALL have parameter Depth, default 4, giving the queue entry count; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter MaxInflight, default 8, giving the maximum number of issued-but-not-done instructions; legal range is 1..15.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port valid_i, input, 1 bit: the scalar core offers an instruction.
REQ-006 SHALL have port ready_o, output, 1 bit: the queue accepts the offered instruction.
REQ-007 SHALL have port insn_i, input, 32 bits: the instruction word.
REQ-008 SHALL have port insn_id_i, input, insn_id_t: the instruction ID.
REQ-009 SHALL have port scalar_reg_i, input, xlen_t: the scalar operand.
REQ-010 SHALL have port vec_context_i, input, vec_context_t: vtype/vl context.
REQ-011 SHALL have port flush_i, input, 1 bit: discard all queued instructions.
REQ-012 SHALL have port issue_valid_o, output, 1 bit: the head entry is offered to rvv_core.
REQ-013 SHALL have port issue_ready_i, input, 1 bit: rvv_core accepts the head entry.
REQ-014 SHALL have ports insn_o (32 bits), insn_id_o (insn_id_t), scalar_reg_o (xlen_t) and vec_context_o (vec_context_t), all outputs, carrying the head entry fields.
REQ-015 SHALL have port done_i, input, 1 bit: rvv_core retired one instruction.
REQ-016 SHALL have port count_o, output, $clog2(Depth)+1 bits: the current queue occupancy.
REQ-017 SHALL have port inflight_o, output, 4 bits: the number of issued-not-done instructions.
REQ-018 SHALL have port err_o, output, 1 bit: sticky underflow error.

Function
REQ-019 SHALL implement a first-word-fall-through FIFO: head fields drive the *_o ports directly from storage.
REQ-020 SHALL enqueue on the cycle where valid_i and ready_o are both high; the entry becomes visible at the head no earlier than the next cycle, and there is no bypass path.
REQ-021 SHALL drive ready_o = (count_o != Depth) and !flush_i; ready_o SHALL NOT depend on issue_ready_i.
REQ-022 SHALL drive issue_valid_o = (count_o != 0) and (inflight_o != MaxInflight) and !flush_i.
REQ-023 SHALL dequeue the head on the cycle where issue_valid_o and issue_ready_i are both high.
REQ-024 SHALL hold the head fields stable while issue_valid_o is high and issue_ready_i is low.
REQ-025 SHALL update count on a simultaneous enqueue and dequeue as count unchanged; when count is Depth, no enqueue occurs even if a dequeue occurs in that cycle.
REQ-026 SHALL use read and write pointers of $clog2(Depth) bits that wrap modulo Depth.
REQ-027 SHALL, on flush_i high, clear count, reset both pointers to 0 on the next edge, ignore valid_i and issue_ready_i that cycle, and leave inflight unchanged.
REQ-028 SHALL update inflight as +1 on a dequeue, -1 on done_i, and unchanged when both occur in the same cycle.
REQ-029 SHALL, on done_i with inflight 0 and no dequeue in the same cycle, keep inflight at 0 and set err_o, which stays high until reset.
REQ-030 SHALL never let inflight exceed MaxInflight (guaranteed by REQ-022).
REQ-031 SHALL leave the contents of storage unused entries unspecified; only head fields qualified by issue_valid_o are meaningful.

Reset
REQ-032 SHALL, while rst_i is high, asynchronously force count_o=0, inflight_o=0, err_o=0 and both pointers to 0, giving issue_valid_o=0 and ready_o=1 (with flush_i low).
REQ-033 SHALL discard all entries on reset asserted mid-operation; entry storage needs no reset.
REQ-034 SHALL resume accepting on the first rising edge after rst_i falls.

Verification
REQ-035 SHALL cover fill: Depth=4, issue_ready_i=0, offer 5 instructions with IDs 0..4 -> IDs 0..3 accepted, ready_o=0 on the 5th, count_o=4.
REQ-036 SHALL cover drain order: then issue_ready_i=1 -> insn_id_o presents 0,1,2,3 on consecutive cycles, count_o reaches 0, issue_valid_o=0.
REQ-037 SHALL cover full with simultaneous dequeue: count=4, valid_i=1, issue_ready_i=1 -> ready_o=0, count becomes 3 next cycle.
REQ-038 SHALL cover the inflight limit: MaxInflight=2, done_i=0, 3 entries queued -> 2 issued, issue_valid_o=0 with count_o=1; one done_i pulse -> the third issues the next cycle, inflight_o=2.
REQ-039 SHALL cover flush: 3 entries queued, flush_i for 1 cycle alongside valid_i=1 -> count_o=0 next cycle, the offered instruction is dropped, inflight_o is unchanged.
REQ-040 SHALL cover underflow and reset: done_i with inflight_o=0 -> err_o=1 and held; rst_i pulse mid-traffic -> all outputs return to their reset values immediately.
